// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the ALU-with-register datapath: queues host commands, issues them one
// at a time as a load/clear pulse, and returns each captured result over a valid/ready port.
module alu_cmd_sequencer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_data,
    input  logic       cmd_clear,
    output logic [2:0] alu_func,
    output logic [3:0] alu_a,
    output logic       alu_load,
    output logic       alu_clear,
    input  logic [7:0] alu_result,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [3:0] res_op,
    output logic [7:0] done_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic       h_clr_q;
    logic [2:0] h_op_q;
    logic [3:0] h_data_q;

    logic [7:0] res_data_q;
    logic [3:0] res_op_q;
    logic [7:0] done_count_q;

    logic push, pop, complete;

    assign cmd_ready = (count_q < CW'(DEPTH)) && !reset;
    assign push      = cmd_valid && cmd_ready;

    // Operands come straight from the hold registers, so they keep the last issued values.
    assign alu_func   = h_op_q;
    assign alu_a      = h_data_q;
    assign res_data   = res_data_q;
    assign res_op     = res_op_q;
    assign done_count = done_count_q;

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        complete  = 1'b0;
        alu_load  = 1'b0;
        alu_clear = 1'b0;
        res_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                // A reset landing in EXEC must not touch the ALU register.
                alu_load  = !h_clr_q && !reset;
                alu_clear = h_clr_q && !reset;
                state_d   = StResp;
            end
            StResp: begin
                res_valid = !reset;
                if (res_ready) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_clear, cmd_op, cmd_data};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            h_clr_q      <= 1'b0;
            h_op_q       <= '0;
            h_data_q     <= '0;
            res_data_q   <= '0;
            res_op_q     <= '0;
            done_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                {h_clr_q, h_op_q, h_data_q} <= mem_q[rd_ptr_q];
                rd_ptr_q                    <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
            if (state_q == StExec) begin
                res_data_q <= h_clr_q ? 8'h00 : alu_result;
                res_op_q   <= {h_clr_q, h_op_q};
            end
            if (complete) begin
                done_count_q <= done_count_q + 8'd1;
            end
        end
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Upstream command stage for the ALU-with-register datapath. It buffers operation commands from a host (switch decoder or test driver) in a small FIFO, issues them one at a time to the ALU as function select plus A operand, and pulses the accumulator-register load or clear. It then captures the ALU result and returns it through a valid/ready result port, so the ALU register is only ever written under sequencer control.

## Interface
- DEPTH, 4, command FIFO depth in entries; power of two, minimum 2
- clock  input  1  rising-edge clock for all state
- reset  input  1  synchronous, active-high; clears all state
- cmd_valid  input  1  host presents a command
- cmd_ready  output  1  FIFO can accept a command; equals (count < DEPTH) and !reset
- cmd_op  input  3  ALU function select
- cmd_data  input  4  A operand
- cmd_clear  input  1  command is "clear register" (op and data are ignored)
- alu_func  output  3  function select to ALU
- alu_a  output  4  A operand to ALU
- alu_load  output  1  one-cycle pulse: ALU register captures alu_result at this edge
- alu_clear  output  1  one-cycle pulse: ALU register clears to 8'h00 at this edge
- alu_result  input  8  combinational ALU output
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_data  output  8  captured result (8'h00 for clear commands)
- res_op  output  4  {clear flag, op} of the command that produced res_data
- done_count  output  8  completed commands, wraps 8'hFF to 8'h00

## Operation
- FIFO: DEPTH x 8 bits ({clear, op, data}), with wrapping read and write pointers and a count of width log2(DEPTH)+1.
- Push occurs when cmd_valid && cmd_ready. When full, cmd_ready=0 and no push occurs. Commands are never dropped or reordered.
- FSM states are IDLE, EXEC, and RESP.
  - IDLE: if FIFO not empty, pop the head into the hold registers (h_clr, h_op, h_data) and go to EXEC. Otherwise stay in IDLE.
  - EXEC (exactly one cycle): alu_func=h_op and alu_a=h_data. If h_clr, assert alu_clear; otherwise assert alu_load. At the same edge, res_data <= (h_clr ? 8'h00 : alu_result) and res_op <= {h_clr, h_op}. Go to RESP.
  - RESP: res_valid=1 and res_data/res_op are held stable. On res_ready, increment done_count and go to IDLE.
- alu_func and alu_a hold the last issued values outside EXEC. They are 0 after reset.
- alu_load and alu_clear are mutually exclusive and are never high outside EXEC.
- A push and a pop in the same cycle are both performed; count is unchanged. A push into an empty FIFO is not visible to IDLE until the following cycle.

## Timing
- Reset values: state=IDLE, FIFO empty, count=0, cmd_ready=0 during reset and 1 in the first cycle after reset, alu_func=0, alu_a=0, alu_load=0, alu_clear=0, res_valid=0, res_data=8'h00, res_op=4'h0, done_count=8'h00.
- Latency: command accepted at edge T into an idle, empty FIFO → pop at T+1 → EXEC during cycle T+1..T+2 with alu_load pulse → res_valid high from edge T+2.
- Throughput: at most one command per 3 cycles with res_ready tied high (IDLE, EXEC, RESP).
- res_valid stays high and res_data stays stable until the handshake completes; res_ready is ignored when res_valid=0.
- Reset while in EXEC or RESP:
  - the in-flight command and all FIFO contents are discarded;
  - no alu_load or alu_clear pulse is issued in the reset cycle;
  - done_count is cleared.
- done_count wrap: 255 completions → 8'hFF; the next completion → 8'h00.

## Test plan
- Reset then single op: push {clr=0, op=3'b001, data=4'h3}; bench ALU drives alu_result=8'h07 during EXEC → exactly one alu_load pulse with alu_func=3'b001 and alu_a=4'h3; res_valid at T+2; res_data=8'h07; res_op=4'h1; done_count=1.
- Clear command: push {clr=1} → one alu_clear pulse and no alu_load; res_data=8'h00; res_op[3]=1.
- Fill and backpressure: hold res_ready=0 and push 5 commands back-to-back. The first command pops; 4 fill the FIFO; cmd_ready=0 at count=4 and the sixth push is refused. Release res_ready → results return in push order, and data values 1..5 appear on alu_a in order.
- Result stall: with res_ready=0 for 10 cycles, res_valid stays 1, res_data is stable, and no further alu_load occurs. With res_ready=1, the next command issues in the following IDLE→EXEC.
- Simultaneous push and pop: count=2 and push during the IDLE pop cycle → count remains 2; pointers wrap correctly across 3 full passes of DEPTH entries.
- Reset mid-operation: assert reset during EXEC with 3 entries queued → all outputs reach their reset values next cycle, no load pulse occurs, and a subsequent single command completes normally with done_count=1.
